keystream_gen: RTL and testbench
================================

KEYSTREAM_GEN -- requirements
Module: keystream_gen

Interface
REQ-001 Parameter N, default 16, keystream word width in bits; legal range 1..64.
REQ-002 Parameter TAPS, default 16'hB400, Galois feedback mask for the 16-bit LFSR (x^16+x^14+x^13+x^11+1).
REQ-003 Parameter SEED, default 16'hACE1, LFSR value after reset and the substitute for an all-zero seed_in.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 seed_load  input  1  load seed_in into the LFSR; honoured only in IDLE.
REQ-008 seed_in  input  16  new LFSR seed.
REQ-009 req  input  1  request one N-bit keystream word.
REQ-010 ks_valid  output  1  ks_word holds a complete word.
REQ-011 ks_ready  input  1  downstream XOR stage accepts ks_word.
REQ-012 ks_word  output  N  keystream word for the downstream bitwise XOR (f = data ^ ks_word).
REQ-013 busy  output  1  high in GEN and VALID.

Function
REQ-014 FSM states SHALL be IDLE, GEN and VALID; encoding is free.
REQ-015 IDLE: seed_load=1 SHALL load lfsr <= (seed_in==0 ? SEED : seed_in); req is ignored in that cycle (seed_load has priority).
REQ-016 IDLE: req=1 with seed_load=0 SHALL enter GEN and clear bit counter cnt to 0.
REQ-017 GEN, each cycle: shift register sh <= {lfsr[0], sh[N-1:1]}; lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0); cnt <= cnt+1.
REQ-018 Bit order: the first LFSR output bit SHALL end up in ks_word[0], the N-th in ks_word[N-1].
REQ-019 GEN SHALL last exactly N cycles; on the edge where cnt==N-1 the FSM SHALL enter VALID.
REQ-020 Latency: req sampled at edge k SHALL give ks_valid=1 after edge k+N.
REQ-021 VALID: ks_valid=1 and ks_word SHALL stay stable until ks_valid&&ks_ready; the LFSR SHALL not step.
REQ-022 On acceptance with req=1 in the same cycle, the FSM SHALL go directly to GEN (back-to-back, no IDLE bubble); with req=0 it SHALL go to IDLE.
REQ-023 ks_ready while ks_valid=0 SHALL have no effect; req and seed_load in GEN or VALID SHALL be ignored, not queued.
REQ-024 The LFSR SHALL never reach 0; state carries across words so successive words are contiguous in the bit sequence.
REQ-025 ks_word SHALL be sh, a register; the value outside VALID is don't-care for the consumer but SHALL be deterministic.
REQ-026 cnt width SHALL be $clog2(N+1).

Reset
REQ-027 rst_n=0 SHALL at once force state=IDLE, lfsr=SEED, sh=0, cnt=0, ks_valid=0, busy=0, ks_word=0.
REQ-028 Reset during GEN or VALID SHALL abort the word; no partial word is presented after release.
REQ-029 The first active edge after rst_n rises SHALL behave as a normal IDLE cycle.

Verification
REQ-030 Reset, seed_load=1 with seed_in=16'h0001, then req pulse, ks_ready=1 (N=16) -> ks_valid exactly 16 cycles after req; ks_word=16'h6801; internal lfsr=16'h7C41.
REQ-031 seed_load with seed_in=16'h0000 -> lfsr=16'hACE1; next word matches a reference model seeded with 16'hACE1.
REQ-032 ks_ready=0 held 5 cycles in VALID -> ks_valid stays 1, ks_word unchanged, lfsr unchanged; accepted on the 6th cycle.
REQ-033 req held high, ks_ready=1, 4 words -> words every N+1 cycles, no IDLE cycle, concatenation equals the first 64 reference-model LFSR bits.
REQ-034 rst_n pulsed low at GEN cnt=7 -> ks_valid=0 and busy=0 immediately; the next request's word equals the first word from SEED.
REQ-035 seed_load and req asserted together in IDLE -> seed loaded, no GEN entry, busy stays 0.

Source files
------------

// File: rtl/keystream_gen_if.sv
// Keystream port bundle: seed/request controls in, keystream word out.
// The master side drives requests and readiness. The slave side is the generator.
interface keystream_if #(
  parameter int N = 16
);
  logic          seed_load;
  logic [15:0]   seed_in;
  logic          req;
  logic          ks_valid;
  logic          ks_ready;
  logic [N-1:0]  ks_word;
  logic          busy;

  modport master (
    output seed_load, seed_in, req, ks_ready,
    input  ks_valid, ks_word, busy
  );

  modport slave (
    input  seed_load, seed_in, req, ks_ready,
    output ks_valid, ks_word, busy
  );
endinterface

// File: rtl/keystream_gen.sv
// Keystream generator.
// A 16-bit Galois LFSR is clocked N times to gather one N-bit word in a
// shift register. The word is then held for the downstream XOR stage until
// that stage accepts it. The LFSR state carries across words, so
// consecutive words form one contiguous bit sequence.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; seed_load reloads the LFSR, req starts a word
//   GEN   | one LFSR bit per cycle shifted into sh, N cycles total
//   VALID | ks_word presented and held; LFSR frozen until ks_ready
module keystream_gen #(
  parameter int          N    = 16,
  parameter logic [15:0] TAPS = 16'hB400,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic      clk,
  input  logic      rst_n,
  keystream_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr, lfsr_nxt, lfsr_step;
  logic [N-1:0]  sh, sh_nxt, sh_shift;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_bit;

  // The x^16 term always feeds back, so a nonzero state never steps to zero.
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);

  // New bits enter at the MSB, so the first bit drifts down to ks_word[0].
  if (N == 1) begin : g_sh_single
    assign sh_shift = lfsr[0];
  end else begin : g_sh_multi
    assign sh_shift = {lfsr[0], sh[N-1:1]};
  end

  assign last_bit = (cnt == CW'(N - 1));

  // Next-state logic, plus the LFSR, shift and count updates.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.seed_load) begin
          lfsr_nxt = (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
        end else if (bus.req) begin
          state_nxt = GEN;
          cnt_nxt   = '0;
        end
      end
      GEN: begin
        sh_nxt   = sh_shift;
        lfsr_nxt = lfsr_step;
        cnt_nxt  = cnt + CW'(1);
        if (last_bit) begin
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (bus.ks_ready) begin
          if (bus.req) begin
            state_nxt = GEN;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr  <= SEED;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.ks_valid = (state == VALID);
  assign bus.busy     = (state != IDLE);
  assign bus.ks_word  = sh;

endmodule

// File: tb/tb_keystream_gen.sv
// Directed bench for keystream_gen with a word-level reference model.
module tb_keystream_gen;
  localparam int          N    = 16;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keystream_if #(.N(N)) bus ();

  keystream_gen #(.N(N), .TAPS(TAPS), .SEED(SEED)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic [N-1:0] ref_word(input logic [15:0] seed);
    logic [15:0]  s;
    logic [N-1:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w[i] = s[0];
      s    = step(s);
    end
    return w;
  endfunction

  // Word-level model: a word's bits are all drawn when it is requested,
  // then the model just counts down N cycles before it expects the word.
  logic [15:0]  m_lfsr  = SEED;
  logic [N-1:0] m_word  = '0;
  int           m_left  = 0;
  logic         m_valid = 1'b0;

  task automatic start_word();
    for (int i = 0; i < N; i++) begin
      m_word[i] = m_lfsr[0];
      m_lfsr    = step(m_lfsr);
    end
    m_left = N;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  = SEED;
      m_left  = 0;
      m_valid = 1'b0;
      m_word  = '0;
    end else if (m_valid) begin
      if (bus.ks_ready) begin
        m_valid = 1'b0;
        if (bus.req) start_word();
      end
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end else if (bus.seed_load) begin
      m_lfsr = (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
    end else if (bus.req) begin
      start_word();
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("ks_valid", bus.ks_valid, m_valid);
    check("busy", bus.busy, m_valid || (m_left != 0));
    if (m_valid) check("ks_word", bus.ks_word, m_word);
    if (m_valid || m_left == 0) check("lfsr", dut.lfsr, m_lfsr);
  end

  task automatic pulse_req();
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.ks_valid && cycles < budget);
    if (!bus.ks_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int           cyc;
    logic [N-1:0] w;
    logic [15:0]  s;
    logic [63:0]  exp_bits, got_bits;

    bus.seed_load = 1'b0;
    bus.seed_in   = 16'h0000;
    bus.req       = 1'b0;
    bus.ks_ready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", bus.ks_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_word", bus.ks_word, 0);
    check("rst_lfsr", dut.lfsr, SEED);
    rst_n = 1'b1;
    @(negedge clk);

    // Seed 0001: known first word and following LFSR state
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0001;
    @(negedge clk);
    bus.seed_load = 1'b0;
    check("seed_0001", dut.lfsr, 16'h0001);
    pulse_req();
    wait_valid(40, cyc);
    check("latency", cyc, N);
    check("word_6801", bus.ks_word, 16'h6801);
    check("lfsr_7c41", dut.lfsr, 16'h7C41);
    check("model_6801", m_word, 16'h6801);
    @(negedge clk);

    // Zero seed falls back to SEED
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    check("zero_seed", dut.lfsr, 16'hACE1);
    pulse_req();
    wait_valid(40, cyc);
    check("word_from_ace1", bus.ks_word, ref_word(16'hACE1));
    @(negedge clk);

    // Back-pressure: 5 cycles held, accepted in the 6th; req/seed_load ignored
    bus.ks_ready = 1'b0;
    pulse_req();
    wait_valid(40, cyc);
    w = bus.ks_word;
    s = dut.lfsr;
    for (int i = 2; i <= 6; i++) begin
      if (i == 3) begin
        bus.req       = 1'b1;
        bus.seed_load = 1'b1;
        bus.seed_in   = 16'h5555;
      end
      @(negedge clk);
      if (i == 3) begin
        bus.req       = 1'b0;
        bus.seed_load = 1'b0;
      end
      check("hold_valid", bus.ks_valid, 1);
      check("hold_word", bus.ks_word, w);
      check("hold_lfsr", dut.lfsr, s);
    end
    bus.ks_ready = 1'b1;
    @(negedge clk);
    check("accepted", bus.ks_valid, 0);
    check("idle_after", bus.busy, 0);

    // Back-to-back words from seed 1234
    bus.seed_load = 1'b1;
    bus.seed_in   = 16'h1234;
    @(negedge clk);
    bus.seed_load = 1'b0;
    s = 16'h1234;
    for (int i = 0; i < 64; i++) begin
      exp_bits[i] = s[0];
      s = step(s);
    end
    bus.req = 1'b1;
    wait_valid(40, cyc);
    got_bits[15:0] = bus.ks_word;
    for (int k = 1; k < 4; k++) begin
      wait_valid(40, cyc);
      check("b2b_period", cyc, N + 1);
      got_bits[16*k +: 16] = bus.ks_word;
    end
    bus.req = 1'b0;
    check("b2b_bits", got_bits, exp_bits);
    @(negedge clk);
    check("b2b_idle", bus.busy, 0);

    // Reset in the middle of GEN
    pulse_req();
    repeat (7) @(negedge clk);
    check("mid_gen_busy", bus.busy, 1);
    check("mid_gen_cnt", dut.cnt, 7);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", bus.ks_valid, 0);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_lfsr", dut.lfsr, SEED);
    pulse_req();
    wait_valid(40, cyc);
    check("abort_latency", cyc, N);
    check("abort_word", bus.ks_word, ref_word(SEED));
    @(negedge clk);

    // seed_load wins over req in IDLE
    bus.seed_load = 1'b1;
    bus.req       = 1'b1;
    bus.seed_in   = 16'hBEEF;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.req       = 1'b0;
    check("prio_busy", bus.busy, 0);
    check("prio_lfsr", dut.lfsr, 16'hBEEF);
    @(negedge clk);
    check("prio_still_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
